// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared widths, owner and FSM encodings for mem_port_arbiter
package mem_port_arbiter_pkg;

  localparam int ADDR_LEN = 32;
  localparam int DATA_LEN = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // Latency counter only has to hold MEM_LAT-1 for MEM_LAT in 1..4
  localparam int LAT_W = 2;

  // Fetch has no size input; it always reads a full word
  localparam logic [2:0] FETCH_FUNCT3 = 3'b010;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// rtl/mem_port_arbiter_arb_pick.sv - fixed data priority with anti-starvation override for fetch
module mem_port_arbiter_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int SC_W       = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic            if_req,
  input  logic            ls_req,
  input  logic [SC_W-1:0] starve_cnt,
  output logic            pick_if,
  output logic            pick_ls
);

  logic starved;

  // Data wins unless fetch has been passed over STARVE_MAX times in a row
  always_comb begin
    pick_if = DISABLE;
    pick_ls = DISABLE;
    starved = if_req && (starve_cnt == SC_W'(STARVE_MAX));
    if (ls_req && !starved) begin
      pick_ls = ENABLE;
    end else if (if_req) begin
      pick_if = ENABLE;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single-port memory (optional ARB_PERF_CNT_EN)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_LEN,
  parameter int DATA_W     = DATA_LEN,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]       perf_conflict,
  output logic [31:0]       perf_starve_force,
`endif
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_hold,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [2:0]        ls_funct3,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_hold,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SC_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

  logic idle_act;
  logic req_if;
  logic req_ls;
  logic pick_if;
  logic pick_ls;
  logic busy_if;
  logic busy_ls;

  // Requests only compete while idle and out of reset, so all grants are 0 during reset
  always_comb begin
    idle_act = rst && (state_q == ST_IDLE);
    req_if   = if_req && idle_act;
    req_ls   = ls_req && idle_act;
  end

  mem_port_arbiter_arb_pick #(
    .SC_W       (SC_W),
    .STARVE_MAX (STARVE_MAX)
  ) u_arb_pick (
    .if_req     (req_if),
    .ls_req     (req_ls),
    .starve_cnt (starve_cnt_q),
    .pick_if    (pick_if),
    .pick_ls    (pick_ls)
  );

  // Issue/wait/respond sequencing, memory pass-through and response steering
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lat_cnt_d  = lat_cnt_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    if_gnt     = DISABLE;
    ls_gnt     = DISABLE;
    if_rvalid  = DISABLE;
    ls_rvalid  = DISABLE;
    mem_en     = DISABLE;
    mem_we     = DISABLE;
    mem_funct3 = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (state_q == ST_IDLE) begin
      if (pick_ls) begin
        ls_gnt     = ENABLE;
        mem_en     = ENABLE;
        mem_we     = ls_we;
        mem_funct3 = ls_funct3;
        mem_addr   = ls_addr;
        mem_wdata  = ls_wdata;
        // Stores finish in the grant cycle; only loads wait for data
        if (!ls_we) begin
          state_d   = ST_BUSY;
          owner_d   = OWN_LS;
          lat_cnt_d = LAT_W'(MEM_LAT - 1);
        end
      end else if (pick_if) begin
        if_gnt     = ENABLE;
        mem_en     = ENABLE;
        mem_funct3 = FETCH_FUNCT3;
        mem_addr   = if_addr;
        state_d    = ST_BUSY;
        owner_d    = OWN_IF;
        lat_cnt_d  = LAT_W'(MEM_LAT - 1);
      end
    end else begin
      if (lat_cnt_q == '0) begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
        if (owner_q == OWN_IF) begin
          if_rvalid  = ENABLE;
          if_rdata_d = mem_rdata;
        end else if (owner_q == OWN_LS) begin
          ls_rvalid  = ENABLE;
          ls_rdata_d = mem_rdata;
        end
      end else begin
        lat_cnt_d = lat_cnt_q - LAT_W'(1);
      end
    end
  end

  // Count data grants that bypass a waiting fetch; any fetch grant or idle fetch clears it
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req || pick_if) begin
      starve_cnt_d = '0;
    end else if (pick_ls && (starve_cnt_q != SC_W'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + SC_W'(1);
    end
  end

  // Read data shows through on the rvalid cycle and is held afterwards; holds cover the wait
  always_comb begin
    busy_if  = (state_q == ST_BUSY) && (owner_q == OWN_IF);
    busy_ls  = (state_q == ST_BUSY) && (owner_q == OWN_LS);
    if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
    ls_rdata = ls_rvalid ? mem_rdata : ls_rdata_q;
    if_hold  = rst && (if_req || busy_if) && !if_rvalid;
    ls_hold  = rst && ((ls_req && !(ls_gnt && ls_we)) || busy_ls) && !ls_rvalid;
  end

  // State, latency, starvation and captured read data registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_NONE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      if_rdata_q   <= '0;
      ls_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      if_rdata_q   <= if_rdata_d;
      ls_rdata_q   <= ls_rdata_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_conflict_q, perf_conflict_d;
  logic [31:0] perf_starve_force_q, perf_starve_force_d;

  // Conflicts are idle cycles with both requesters present; forced fetches beat a live data request
  always_comb begin
    perf_conflict_d     = perf_conflict_q;
    perf_starve_force_d = perf_starve_force_q;
    if (req_if && req_ls) begin
      perf_conflict_d = perf_conflict_q + 32'd1;
    end
    if (pick_if && req_ls) begin
      perf_starve_force_d = perf_starve_force_q + 32'd1;
    end
    perf_conflict     = perf_conflict_q;
    perf_starve_force = perf_starve_force_q;
  end

  // Free-running wrap-around performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_conflict_q     <= '0;
      perf_starve_force_q <= '0;
    end else begin
      perf_conflict_q     <= perf_conflict_d;
      perf_starve_force_q <= perf_starve_force_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        ls_req;
  logic        ls_we;
  logic [2:0]  ls_funct3;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [31:0] mem_rdata;

  logic        if_gnt, if_rvalid, if_hold, ls_gnt, ls_rvalid, ls_hold, mem_en, mem_we;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic [2:0]  mem_funct3;

  logic        l3_if_gnt, l3_if_rvalid, l3_if_hold, l3_ls_gnt, l3_ls_rvalid, l3_ls_hold;
  logic        l3_mem_en, l3_mem_we;
  logic [31:0] l3_if_rdata, l3_ls_rdata, l3_mem_addr, l3_mem_wdata;
  logic [2:0]  l3_mem_funct3;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_conflict, perf_starve_force;
  logic [31:0] l3_perf_conflict, l3_perf_starve_force;
`endif

  int checks;
  int failures;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(3)) u_dut (
    .clk        (clk),
    .rst        (rst),
`ifdef ARB_PERF_CNT_EN
    .perf_conflict     (perf_conflict),
    .perf_starve_force (perf_starve_force),
`endif
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .if_hold    (if_hold),
    .ls_req     (ls_req),
    .ls_we      (ls_we),
    .ls_funct3  (ls_funct3),
    .ls_addr    (ls_addr),
    .ls_wdata   (ls_wdata),
    .ls_gnt     (ls_gnt),
    .ls_rvalid  (ls_rvalid),
    .ls_rdata   (ls_rdata),
    .ls_hold    (ls_hold),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_funct3 (mem_funct3),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(3)) u_lat3 (
    .clk        (clk),
    .rst        (rst),
`ifdef ARB_PERF_CNT_EN
    .perf_conflict     (l3_perf_conflict),
    .perf_starve_force (l3_perf_starve_force),
`endif
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (l3_if_gnt),
    .if_rvalid  (l3_if_rvalid),
    .if_rdata   (l3_if_rdata),
    .if_hold    (l3_if_hold),
    .ls_req     (ls_req),
    .ls_we      (ls_we),
    .ls_funct3  (ls_funct3),
    .ls_addr    (ls_addr),
    .ls_wdata   (ls_wdata),
    .ls_gnt     (l3_ls_gnt),
    .ls_rvalid  (l3_ls_rvalid),
    .ls_rdata   (l3_ls_rdata),
    .ls_hold    (l3_ls_hold),
    .mem_en     (l3_mem_en),
    .mem_we     (l3_mem_we),
    .mem_funct3 (l3_mem_funct3),
    .mem_addr   (l3_mem_addr),
    .mem_wdata  (l3_mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ifr;
    logic        lsr;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] iaddr;
    logic [31:0] laddr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    logic        eig;
    logic        elg;
    logic        een;
    logic        ewe;
    logic [31:0] eaddr;
    logic [31:0] ewdata;
    logic        eirv;
    logic        elrv;
    logic [31:0] erdata;
    logic        eih;
    logic        elh;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ifr, input logic [31:0] ia, input logic lsr, input logic we,
                       input logic [2:0] f3, input logic [31:0] la, input logic [31:0] wd,
                       input logic [31:0] mrd);
    if_req    = ifr;
    if_addr   = ia;
    ls_req    = lsr;
    ls_we     = we;
    ls_funct3 = f3;
    ls_addr   = la;
    ls_wdata  = wd;
    mem_rdata = mrd;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    drive(1'b1, 32'h10, 1'b1, 1'b0, 3'b010, 32'h100, 32'h5, 32'hFFFF_FFFF);

    //             ifr lsr we  f3      iaddr  laddr  wdata          mrd            eig elg een ewe eaddr  ewdata         eirv elrv erdata         eih elh
    vecs[0]  = '{1'b1,1'b0,1'b0,3'b000,32'h10,32'h0, 32'h0,          32'h0,         1'b1,1'b0,1'b1,1'b0,32'h10, 32'h0,          1'b0,1'b0,32'h0,          1'b1,1'b0};
    vecs[1]  = '{1'b0,1'b0,1'b0,3'b000,32'h10,32'h0, 32'h0,          32'h0050_0093, 1'b0,1'b0,1'b0,1'b0,32'h0,  32'h0,          1'b1,1'b0,32'h0050_0093,  1'b0,1'b0};
    vecs[2]  = '{1'b1,1'b1,1'b1,3'b010,32'h14,32'h100,32'hDEAD_BEEF, 32'h0,         1'b0,1'b1,1'b1,1'b1,32'h100,32'hDEAD_BEEF,  1'b0,1'b0,32'h0,          1'b1,1'b0};
    vecs[3]  = '{1'b1,1'b0,1'b0,3'b000,32'h14,32'h0, 32'h0,          32'h0,         1'b1,1'b0,1'b1,1'b0,32'h14, 32'h0,          1'b0,1'b0,32'h0,          1'b1,1'b0};
    vecs[4]  = '{1'b0,1'b0,1'b0,3'b000,32'h0, 32'h0, 32'h0,          32'h1111_2222, 1'b0,1'b0,1'b0,1'b0,32'h0,  32'h0,          1'b1,1'b0,32'h1111_2222,  1'b0,1'b0};
    vecs[5]  = '{1'b1,1'b1,1'b0,3'b100,32'h20,32'h200,32'h0,         32'h0,         1'b0,1'b1,1'b1,1'b0,32'h200,32'h0,          1'b0,1'b0,32'h0,          1'b1,1'b1};
    vecs[6]  = '{1'b1,1'b1,1'b0,3'b100,32'h20,32'h204,32'h0,         32'hA0A0_0001, 1'b0,1'b0,1'b0,1'b0,32'h0,  32'h0,          1'b0,1'b1,32'hA0A0_0001,  1'b1,1'b0};
    vecs[7]  = '{1'b1,1'b1,1'b0,3'b001,32'h20,32'h204,32'h0,         32'h0,         1'b0,1'b1,1'b1,1'b0,32'h204,32'h0,          1'b0,1'b0,32'h0,          1'b1,1'b1};
    vecs[8]  = '{1'b1,1'b1,1'b0,3'b001,32'h20,32'h208,32'h0,         32'hA0A0_0002, 1'b0,1'b0,1'b0,1'b0,32'h0,  32'h0,          1'b0,1'b1,32'hA0A0_0002,  1'b1,1'b0};
    vecs[9]  = '{1'b1,1'b1,1'b0,3'b000,32'h20,32'h208,32'h0,         32'h0,         1'b0,1'b1,1'b1,1'b0,32'h208,32'h0,          1'b0,1'b0,32'h0,          1'b1,1'b1};
    vecs[10] = '{1'b1,1'b1,1'b0,3'b000,32'h20,32'h20C,32'h0,         32'hA0A0_0003, 1'b0,1'b0,1'b0,1'b0,32'h0,  32'h0,          1'b0,1'b1,32'hA0A0_0003,  1'b1,1'b0};
    vecs[11] = '{1'b1,1'b1,1'b0,3'b000,32'h20,32'h20C,32'h0,         32'h0,         1'b1,1'b0,1'b1,1'b0,32'h20, 32'h0,          1'b0,1'b0,32'h0,          1'b1,1'b1};
    vecs[12] = '{1'b1,1'b1,1'b0,3'b000,32'h24,32'h20C,32'h0,         32'h0000_0013, 1'b0,1'b0,1'b0,1'b0,32'h0,  32'h0,          1'b1,1'b0,32'h0000_0013,  1'b0,1'b1};
    vecs[13] = '{1'b1,1'b1,1'b0,3'b010,32'h24,32'h20C,32'h0,         32'h0,         1'b0,1'b1,1'b1,1'b0,32'h20C,32'h0,          1'b0,1'b0,32'h0,          1'b1,1'b1};
    vecs[14] = '{1'b0,1'b0,1'b0,3'b000,32'h0, 32'h0, 32'h0,          32'hBBBB_0000, 1'b0,1'b0,1'b0,1'b0,32'h0,  32'h0,          1'b0,1'b1,32'hBBBB_0000,  1'b0,1'b0};
    vecs[15] = '{1'b1,1'b0,1'b0,3'b000,32'h30,32'h0, 32'h0,          32'h0,         1'b1,1'b0,1'b1,1'b0,32'h30, 32'h0,          1'b0,1'b0,32'h0,          1'b1,1'b0};
    vecs[16] = '{1'b0,1'b1,1'b1,3'b010,32'h0, 32'h300,32'h55,        32'h0CC0_0000, 1'b0,1'b0,1'b0,1'b0,32'h0,  32'h0,          1'b1,1'b0,32'h0CC0_0000,  1'b0,1'b1};
    vecs[17] = '{1'b0,1'b0,1'b0,3'b000,32'h0, 32'h0, 32'h0,          32'h0,         1'b0,1'b0,1'b0,1'b0,32'h0,  32'h0,          1'b0,1'b0,32'h0,          1'b0,1'b0};
    vecs[18] = '{1'b0,1'b0,1'b0,3'b000,32'h0, 32'h0, 32'h0,          32'h0,         1'b0,1'b0,1'b0,1'b0,32'h0,  32'h0,          1'b0,1'b0,32'h0,          1'b0,1'b0};

    // Reset state with requests present and nonzero memory data
    repeat (2) @(negedge clk);
    #1;
    chk("rst_if_gnt",    {31'd0, if_gnt},    32'd0);
    chk("rst_ls_gnt",    {31'd0, ls_gnt},    32'd0);
    chk("rst_if_hold",   {31'd0, if_hold},   32'd0);
    chk("rst_ls_hold",   {31'd0, ls_hold},   32'd0);
    chk("rst_mem_en",    {31'd0, mem_en},    32'd0);
    chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rst_mem_addr",  mem_addr,           32'd0);
    chk("rst_mem_wdata", mem_wdata,          32'd0);
    chk("rst_if_rdata",  if_rdata,           32'd0);
    chk("rst_ls_rdata",  ls_rdata,           32'd0);

    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    rst = 1'b1;

    // Table: single-cycle behaviour for MEM_LAT=1, STARVE_MAX=3
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i].ifr, vecs[i].iaddr, vecs[i].lsr, vecs[i].we, vecs[i].f3,
            vecs[i].laddr, vecs[i].wdata, vecs[i].mrd);
      #1;
      chk($sformatf("r%0d_if_gnt", i),    {31'd0, if_gnt},    {31'd0, vecs[i].eig});
      chk($sformatf("r%0d_ls_gnt", i),    {31'd0, ls_gnt},    {31'd0, vecs[i].elg});
      chk($sformatf("r%0d_mem_en", i),    {31'd0, mem_en},    {31'd0, vecs[i].een});
      chk($sformatf("r%0d_mem_we", i),    {31'd0, mem_we},    {31'd0, vecs[i].ewe});
      chk($sformatf("r%0d_if_rvalid", i), {31'd0, if_rvalid}, {31'd0, vecs[i].eirv});
      chk($sformatf("r%0d_ls_rvalid", i), {31'd0, ls_rvalid}, {31'd0, vecs[i].elrv});
      chk($sformatf("r%0d_if_hold", i),   {31'd0, if_hold},   {31'd0, vecs[i].eih});
      chk($sformatf("r%0d_ls_hold", i),   {31'd0, ls_hold},   {31'd0, vecs[i].elh});
      if (vecs[i].een) chk($sformatf("r%0d_mem_addr", i), mem_addr, vecs[i].eaddr);
      if (vecs[i].elg) begin
        chk($sformatf("r%0d_mem_wdata", i),  mem_wdata,           vecs[i].ewdata);
        chk($sformatf("r%0d_mem_funct3", i), {29'd0, mem_funct3}, {29'd0, vecs[i].f3});
      end
      if (vecs[i].eirv) chk($sformatf("r%0d_if_rdata", i), if_rdata, vecs[i].erdata);
      if (vecs[i].elrv) chk($sformatf("r%0d_ls_rdata", i), ls_rdata, vecs[i].erdata);
    end

    // Read data stays held after its rvalid cycle
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h1234_5678);
    #1;
    chk("held_if_rdata", if_rdata, 32'h0CC0_0000);
    chk("held_ls_rdata", ls_rdata, 32'hBBBB_0000);
`ifdef ARB_PERF_CNT_EN
    chk("perf_conflict",     perf_conflict,     32'd6);
    chk("perf_starve_force", perf_starve_force, 32'd1);
`endif

    // MEM_LAT=3 load while fetch waits
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 32'h40, 1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h0);
    #1;
    chk("l3_ls_gnt",   {31'd0, l3_ls_gnt}, 32'd1);
    chk("l3_if_gnt0",  {31'd0, l3_if_gnt}, 32'd0);
    chk("l3_mem_addr", l3_mem_addr,        32'h200);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      drive(1'b1, 32'h40, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
      #1;
      chk($sformatf("l3_c%0d_if_gnt", c),    {31'd0, l3_if_gnt},    32'd0);
      chk($sformatf("l3_c%0d_mem_en", c),    {31'd0, l3_mem_en},    32'd0);
      chk($sformatf("l3_c%0d_ls_rvalid", c), {31'd0, l3_ls_rvalid}, 32'd0);
      chk($sformatf("l3_c%0d_if_hold", c),   {31'd0, l3_if_hold},   32'd1);
      chk($sformatf("l3_c%0d_ls_hold", c),   {31'd0, l3_ls_hold},   32'd1);
    end
    @(negedge clk);
    mem_rdata = 32'h7766_5544;
    #1;
    chk("l3_c3_ls_rvalid", {31'd0, l3_ls_rvalid}, 32'd1);
    chk("l3_c3_ls_rdata",  l3_ls_rdata,           32'h7766_5544);
    chk("l3_c3_if_gnt",    {31'd0, l3_if_gnt},    32'd0);
    chk("l3_c3_if_hold",   {31'd0, l3_if_hold},   32'd1);
    @(negedge clk);
    mem_rdata = 32'h0;
    #1;
    chk("l3_c4_if_gnt",   {31'd0, l3_if_gnt}, 32'd1);
    chk("l3_c4_mem_addr", l3_mem_addr,        32'h40);

    // Reset during an outstanding fetch read drops it
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 32'h50, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    #1;
    chk("mid_first_gnt", {31'd0, if_gnt}, 32'd1);
    @(negedge clk);
    mem_rdata = 32'h0000_0099;
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("mid_rst_if_gnt",    {31'd0, if_gnt},    32'd0);
    chk("mid_rst_if_hold",   {31'd0, if_hold},   32'd0);
    chk("mid_rst_mem_en",    {31'd0, mem_en},    32'd0);
    chk("mid_rst_if_rdata",  if_rdata,           32'd0);
    chk("mid_rst_mem_addr",  mem_addr,           32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 32'h60, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    #1;
    chk("post_rst_if_gnt",    {31'd0, if_gnt},    32'd1);
    chk("post_rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("post_rst_mem_addr",  mem_addr,           32'h60);

    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
